register_bank: RTL and testbench

Storage stage of the register file: 32 general registers of DATA_WIDTH bits, one synchronous write port, and a per-register pending-write scoreboard. All 32 register values are presented in parallel on a flat bus that feeds the 32:1 read multiplexers directly. Register 0 is hardwired to zero. A combinational hazard flag lets issue logic stall when a source operand still has a write outstanding.

---
 rtl/register_bank.sv | 57 +++++
 tb/tb_register_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// Register file storage: 32 x DATA_WIDTH registers with one write port and a
// per-register pending-write (busy) scoreboard; r0 is hardwired to zero.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           wr_en_i,
    input  logic [4:0]                     wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           rsv_en_i,
    input  logic [4:0]                     rsv_addr_i,
    input  logic [4:0]                     src_a_addr_i,
    input  logic [4:0]                     src_b_addr_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            busy_o,
    output logic                           hazard_o
);

    assign regs_o[DATA_WIDTH-1:0] = '0;
    assign busy_o[0]              = 1'b0;

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_reg
        logic [DATA_WIDTH-1:0] data_q;
        logic                  busy_q;
        logic                  wr_hit;
        logic                  rsv_hit;

        assign wr_hit  = wr_en_i  && (wr_addr_i  == 5'(k));
        assign rsv_hit = rsv_en_i && (rsv_addr_i == 5'(k));

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                if (wr_hit) begin
                    data_q <= wr_data_i;
                end
                // A same-edge reserve marks a newer producer, so it beats the clear.
                if (rsv_hit) begin
                    busy_q <= 1'b1;
                end else if (wr_hit) begin
                    busy_q <= 1'b0;
                end
            end
        end

        assign regs_o[DATA_WIDTH*k +: DATA_WIDTH] = data_q;
        assign busy_o[k]                          = busy_q;
    end

    // busy_o[0] is constant 0, so a zero source address never flags a hazard.
    assign hazard_o = busy_o[src_a_addr_i] | busy_o[src_b_addr_i];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random traffic
// compared against an array-based model of the register file and scoreboard.
module tb_register_bank;

    localparam int W = 32;
    localparam int N = 32;

    logic           clk_i = 1'b0;
    logic           rst_n_i;
    logic           wr_en_i;
    logic [4:0]     wr_addr_i;
    logic [W-1:0]   wr_data_i;
    logic           rsv_en_i;
    logic [4:0]     rsv_addr_i;
    logic [4:0]     src_a_addr_i;
    logic [4:0]     src_b_addr_i;
    logic [N*W-1:0] regs_o;
    logic [N-1:0]   busy_o;
    logic           hazard_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_regs [N];
    bit           m_busy [N];

    register_bank #(.DATA_WIDTH(W), .NUM_REGS(N)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rsv_en_i(rsv_en_i), .rsv_addr_i(rsv_addr_i),
        .src_a_addr_i(src_a_addr_i), .src_b_addr_i(src_b_addr_i),
        .regs_o(regs_o), .busy_o(busy_o), .hazard_o(hazard_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, written from the behavioural rules.
    task automatic model_edge();
        if (!rst_n_i) begin
            for (int k = 0; k < N; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end else begin
            if (wr_en_i) begin
                if (wr_addr_i != 0) m_regs[wr_addr_i] = wr_data_i;
                m_busy[wr_addr_i] = 1'b0;
            end
            if (rsv_en_i && rsv_addr_i != 0) m_busy[rsv_addr_i] = 1'b1;
        end
    endtask

    function automatic logic exp_hazard();
        return (src_a_addr_i != 0 && m_busy[src_a_addr_i]) ||
               (src_b_addr_i != 0 && m_busy[src_b_addr_i]);
    endfunction

    task automatic check_hazard();
        chk("hazard", 64'(hazard_o), 64'(exp_hazard()));
    endtask

    task automatic check_all();
        logic [N-1:0] eb;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("slice%0d", k), 64'(regs_o[k*W +: W]), 64'(m_regs[k]));
            eb[k] = m_busy[k];
        end
        chk("busy", 64'(busy_o), 64'(eb));
        check_hazard();
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rst_n_i = 1'b1; wr_en_i = 1'b0; rsv_en_i = 1'b0;
    endtask

    task automatic drive_wr(input logic [4:0] a, input logic [W-1:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    endtask

    task automatic drive_rsv(input logic [4:0] a);
        rsv_en_i = 1'b1; rsv_addr_i = a;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_regs[k] = 'x;
            m_busy[k] = 1'b0;
        end
        rst_n_i = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        rsv_en_i = 1'b0; rsv_addr_i = '0; src_a_addr_i = '0; src_b_addr_i = '0;

        // Reset for two cycles, then write r5.
        step();
        step();
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_hazard", 64'(hazard_o), 64'd0);
        idle(); drive_wr(5'd5, 32'hDEADBEEF);
        step();
        chk("r5_written", 64'(regs_o[5*W +: W]), 64'hDEADBEEF);

        // r0 protection.
        idle(); drive_wr(5'd0, 32'hFFFFFFFF); drive_rsv(5'd0);
        src_a_addr_i = 5'd0; src_b_addr_i = 5'd0;
        step();
        chk("r0_data", 64'(regs_o[W-1:0]), 64'd0);
        chk("r0_busy", 64'(busy_o[0]), 64'd0);
        chk("r0_hazard", 64'(hazard_o), 64'd0);

        // Reserve r7, then clear it with a write.
        idle(); drive_rsv(5'd7); src_a_addr_i = 5'd7;
        step();
        chk("r7_busy", 64'(busy_o), 64'h80);
        chk("r7_hazard", 64'(hazard_o), 64'd1);
        idle(); drive_wr(5'd7, 32'h12345678);
        step();
        chk("r7_clear_busy", 64'(busy_o), 64'd0);
        chk("r7_clear_hazard", 64'(hazard_o), 64'd0);
        chk("r7_data", 64'(regs_o[7*W +: W]), 64'h12345678);

        // Same-edge reserve and write on an already-busy r9.
        idle(); drive_rsv(5'd9);
        step();
        idle(); drive_rsv(5'd9); drive_wr(5'd9, 32'hA5A5_0909);
        step();
        chk("r9_data", 64'(regs_o[9*W +: W]), 64'hA5A50909);
        chk("r9_busy", 64'(busy_o[9]), 64'd1);

        // Parallel reserve r3 and write r4; hazard through source b.
        idle(); drive_rsv(5'd3); drive_wr(5'd4, 32'h0000_4444);
        src_a_addr_i = 5'd0; src_b_addr_i = 5'd3;
        step();
        chk("par_busy3", 64'(busy_o[3]), 64'd1);
        chk("par_busy4", 64'(busy_o[4]), 64'd0);
        chk("par_r4", 64'(regs_o[4*W +: W]), 64'h4444);
        chk("par_hazard", 64'(hazard_o), 64'd1);

        // Hazard is combinational in the source addresses.
        idle();
        src_a_addr_i = 5'd9; src_b_addr_i = 5'd0; #1; check_hazard();
        src_a_addr_i = 5'd4; src_b_addr_i = 5'd5; #1; check_hazard();
        chk("comb_hazard_clear", 64'(hazard_o), 64'd0);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst_n_i      = ($urandom_range(0, 49) != 0);
            wr_en_i      = $urandom_range(0, 1);
            wr_addr_i    = 5'($urandom_range(0, 31));
            wr_data_i    = $urandom;
            rsv_en_i     = $urandom_range(0, 1);
            rsv_addr_i   = ($urandom_range(0, 3) == 0) ? wr_addr_i : 5'($urandom_range(0, 31));
            src_a_addr_i = 5'($urandom_range(0, 31));
            src_b_addr_i = 5'($urandom_range(0, 31));
            step();
            src_a_addr_i = 5'($urandom_range(0, 31));
            #1; check_hazard();
        end

        // Load r1..r31 with k, reserve r10, then reset alongside a write.
        for (int k = 1; k < N; k++) begin
            idle(); drive_wr(5'(k), W'(k));
            step();
        end
        idle(); drive_rsv(5'd10); src_a_addr_i = 5'd10;
        step();
        chk("pre_reset_hazard", 64'(hazard_o), 64'd1);
        chk("pre_reset_r31", 64'(regs_o[31*W +: W]), 64'd31);
        idle(); rst_n_i = 1'b0; drive_wr(5'd2, 32'hCAFEF00D);
        step();
        chk("mid_reset_regs", 64'(regs_o == '0), 64'd1);
        chk("mid_reset_busy", 64'(busy_o), 64'd0);
        chk("mid_reset_hazard", 64'(hazard_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
